cpu_regfile_wb_arbiter: RTL and testbench

- Shares the CPU register file's single write port (a3/wd3/we3) between two writeback requesters: port 0 for ALU/execute results and port 1 for load data returning from memory.
- Round-robin arbitration on contention, with one registered output stage.
- Keeps a pending-write scoreboard (busy mask) that decode uses to stall on RAW hazards.
- Sits between the execute/memory stages and the register file.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/cpu_wb_rr_arbiter.sv | 30 +++
 rtl/cpu_regfile_wb_arbiter.sv | 84 ++++++++
 tb/tb_cpu_regfile_wb_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU writeback definitions: data/address widths, the writeback
// request bundle and the requester port indices.
package cpu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic PORT_EXEC = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/cpu_wb_rr_arbiter.sv
// Two-way round-robin grant generator. The pointer only moves on a contended
// grant, so a lone requester never disturbs the fairness order.
module cpu_wb_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic rr_ptr_q;
    logic rr_ptr_d;

    always_comb begin
        gnt      = req;
        rr_ptr_d = rr_ptr_q;
        if (&req) begin
            gnt      = rr_ptr_q ? 2'b10 : 2'b01;
            rr_ptr_d = ~rr_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/cpu_regfile_wb_arbiter.sv
// Shares the register file write port between execute and load writebacks,
// registers the winning write, and tracks pending writes for RAW stalls.
module cpu_regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned REGS = 32,
    parameter int unsigned XLEN = cpu_pkg::XLEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb0_valid,
    input  logic [REG_ADDR_W-1:0] wb0_rd,
    input  logic [XLEN-1:0]       wb0_data,
    output logic                  wb0_ready,
    input  logic                  wb1_valid,
    input  logic [REG_ADDR_W-1:0] wb1_rd,
    input  logic [XLEN-1:0]       wb1_data,
    output logic                  wb1_ready,
    input  logic                  alloc_valid,
    input  logic [REG_ADDR_W-1:0] alloc_rd,
    output logic [REG_ADDR_W-1:0] a3,
    output logic [XLEN-1:0]       wd3,
    output logic                  we3,
    output logic [REGS-1:0]       busy
);

    logic [1:0]            gnt;
    logic                  grant;
    logic [REG_ADDR_W-1:0] win_rd;
    logic [XLEN-1:0]       win_data;

    logic                  we3_q,  we3_d;
    logic [REG_ADDR_W-1:0] a3_q,   a3_d;
    logic [XLEN-1:0]       wd3_q,  wd3_d;
    logic [REGS-1:0]       busy_q, busy_d;

    cpu_wb_rr_arbiter u_rr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({wb1_valid, wb0_valid}),
        .gnt   (gnt)
    );

    assign wb0_ready = gnt[PORT_EXEC];
    assign wb1_ready = gnt[PORT_LOAD];
    assign grant     = |gnt;
    assign win_rd    = gnt[PORT_LOAD] ? wb1_rd   : wb0_rd;
    assign win_data  = gnt[PORT_LOAD] ? wb1_data : wb0_data;

    always_comb begin
        we3_d  = grant && (win_rd != '0);
        a3_d   = grant ? win_rd   : a3_q;
        wd3_d  = grant ? win_data : wd3_q;
        busy_d = busy_q;
        if (grant) begin
            busy_d[win_rd] = 1'b0;
        end
        // Allocation is applied last: a newer producer outranks a retiring one.
        if (alloc_valid) begin
            busy_d[alloc_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_q  <= 1'b0;
            a3_q   <= '0;
            wd3_q  <= '0;
            busy_q <= '0;
        end else begin
            we3_q  <= we3_d;
            a3_q   <= a3_d;
            wd3_q  <= wd3_d;
            busy_q <= busy_d;
        end
    end

    assign we3  = we3_q;
    assign a3   = a3_q;
    assign wd3  = wd3_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_cpu_regfile_wb_arbiter.sv
// Scoreboard bench for cpu_regfile_wb_arbiter: directed writebacks push the
// expected register-file write; a monitor pops and checks each we3 pulse.
module tb_cpu_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wb0_valid, wb1_valid, alloc_valid;
    logic [4:0]  wb0_rd, wb1_rd, alloc_rd;
    logic [31:0] wb0_data, wb1_data;
    logic        wb0_ready, wb1_ready;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        we3;
    logic [31:0] busy;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] exp_busy;
    int          n0, n1;
    int          exp_g[4] = '{0, 1, 0, 1};

    cpu_regfile_wb_arbiter #(.REGS(32), .XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb0_valid   (wb0_valid),
        .wb0_rd      (wb0_rd),
        .wb0_data    (wb0_data),
        .wb0_ready   (wb0_ready),
        .wb1_valid   (wb1_valid),
        .wb1_rd      (wb1_rd),
        .wb1_data    (wb1_data),
        .wb1_ready   (wb1_ready),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .a3          (a3),
        .wd3         (wd3),
        .we3         (we3),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Acceptance happens on the coming posedge; the write is visible right after it.
    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                         input logic av, input logic [4:0] ar);
        @(negedge clk);
        chk("busy", {32'h0, busy}, {32'h0, exp_busy});
        wb0_valid = v0; wb0_rd = r0; wb0_data = d0;
        wb1_valid = v1; wb1_rd = r1; wb1_data = d1;
        alloc_valid = av; alloc_rd = ar;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("idle_ready", {62'h0, wb1_ready, wb0_ready}, 64'h0);
    endtask

    // Monitor: every we3 pulse must match the oldest expected write.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (we3 === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got a3=%0d wd3=0x%0h expected no write (t=%0t)",
                             a3, wd3, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {59'h0, a3}, {59'h0, e.rd});
                    chk("wr_data", {32'h0, wd3}, {32'h0, e.data});
                    chk("wr_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
        wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
        alloc_valid = 0; alloc_rd = 0;
        exp_busy = 32'h0;
        #3;
        chk("rst_we3",  {63'h0, we3}, 64'h0);
        chk("rst_a3",   {59'h0, a3}, 64'h0);
        chk("rst_wd3",  {32'h0, wd3}, 64'h0);
        chk("rst_busy", {32'h0, busy}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single execute write
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("t1_ready", {62'h0, wb1_ready, wb0_ready}, 64'h1);
        push(5'd5, 32'hDEADBEEF);
        idle();

        // Contention: grants alternate 0,1,0,1; losers hold their request
        n0 = 0; n1 = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'd1, 32'h100 + 32'(n0), 1'b1, 5'd2, 32'h200 + 32'(n1), 1'b0, 5'd0);
            chk("t2_ready", {62'h0, wb1_ready, wb0_ready}, (exp_g[k] == 1) ? 64'h2 : 64'h1);
            if (exp_g[k] == 0) begin
                push(5'd1, 32'h100 + 32'(n0));
                n0++;
            end else begin
                push(5'd2, 32'h200 + 32'(n1));
                n1++;
            end
        end
        idle();

        // Alloc x7, retire it two cycles later through the load port
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        exp_busy = 32'h0000_0080;
        idle();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
        chk("t3_ready", {62'h0, wb1_ready, wb0_ready}, 64'h2);
        push(5'd7, 32'h77);
        exp_busy = 32'h0;
        idle();

        // Alloc and retire x9 on the same edge: set wins
        drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        chk("t4_ready", {62'h0, wb1_ready, wb0_ready}, 64'h1);
        push(5'd9, 32'h99);
        exp_busy = 32'h0000_0200;
        idle();

        // x0 writes and allocs are inert
        drive(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("t5_ready", {62'h0, wb1_ready, wb0_ready}, 64'h1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
        idle();

        // Build busy=0x84 with a write in flight and a contended grant, then reset mid-cycle
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9A, 1'b1, 5'd2);
        chk("t6a_ready", {62'h0, wb1_ready, wb0_ready}, 64'h2);
        push(5'd9, 32'h9A);
        exp_busy = 32'h0000_0004;
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd11, 32'hBB, 1'b1, 5'd7);
        chk("t6b_ready", {62'h0, wb1_ready, wb0_ready}, 64'h1);
        push(5'd3, 32'h33);
        exp_busy = 32'h0000_0084;
        @(posedge clk);
        #4;
        chk("pre_rst_busy", {32'h0, busy}, 64'h84);
        chk("pre_rst_we3", {63'h0, we3}, 64'h1);
        rst_n = 1'b0;
        wb0_valid = 0; wb1_valid = 0; alloc_valid = 0;
        #1;
        chk("async_we3",  {63'h0, we3}, 64'h0);
        chk("async_busy", {32'h0, busy}, 64'h0);
        chk("async_a3",   {59'h0, a3}, 64'h0);
        chk("async_wd3",  {32'h0, wd3}, 64'h0);
        exp_busy = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Pointer restarts favouring port 0
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
        chk("t7a_ready", {62'h0, wb1_ready, wb0_ready}, 64'h1);
        push(5'd4, 32'h44);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
        chk("t7b_ready", {62'h0, wb1_ready, wb0_ready}, 64'h2);
        push(5'd6, 32'h66);
        idle();
        idle();

        for (int w = 0; w < 5 && exp_q.size() != 0; w++) @(negedge clk);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_write: got no write expected a3=%0d wd3=0x%0h", e.rd, e.data);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
